// File: rtl/rast_pkg.sv
// Shared rasterizer definitions: walk FSM states and the subsample-grid helpers.
package rast_pkg;

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_TEST = 1'b1
    } state_t;

    // One-hot MSAA select to grid pitch; [3] is the full pixel, each lower bit halves it.
    function automatic int step_lookup(input logic [3:0] sub_sample, input int radix);
        int unit;
        unit = 1 << radix;
        case (sub_sample)
            4'b1000: return unit;
            4'b0100: return unit >>> 1;
            4'b0010: return unit >>> 2;
            4'b0001: return unit >>> 3;
            default: return unit;
        endcase
    endfunction

    function automatic int lane_offset(input int lane, input int step);
        return lane * step;
    endfunction

endpackage

// File: rtl/sample_lane_gen.sv
// Combinational lane expansion: SAMPS horizontally adjacent samples from the walk cursor.
module sample_lane_gen
    import rast_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int SAMPS  = 4
) (
    input  logic signed [SIGFIG:0]   i_cur_x,
    input  logic signed [SIGFIG-1:0] i_cur_y,
    input  logic signed [SIGFIG:0]   i_ur_x,
    input  logic signed [SIGFIG:0]   i_step,
    output logic signed [SIGFIG-1:0] o_lane_x [SAMPS],
    output logic signed [SIGFIG-1:0] o_lane_y,
    output logic [SAMPS-1:0]         o_lane_vld
);

    logic signed [SIGFIG:0] w_x [SAMPS];

    // The extra top bit keeps the in-box compare honest for lanes past the coordinate range.
    always_comb begin
        for (int k = 0; k < SAMPS; k++) begin
            w_x[k]        = i_cur_x + (SIGFIG+1)'(lane_offset(k, int'(i_step)));
            o_lane_x[k]   = $signed(w_x[k][SIGFIG-1:0]);
            o_lane_vld[k] = (w_x[k] <= i_ur_x);
        end
        o_lane_y = i_cur_y;
    end

endmodule

// File: rtl/sample_iter_multi.sv
// Bounding-box walker: accepts one triangle, then emits SAMPS samples per cycle in row-major order.
module sample_iter_multi
    import rast_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic [SIGFIG-1:0]        color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic [3:0]               subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic [SIGFIG-1:0]        color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2][SAMPS],
    output logic [SAMPS-1:0]         validSamp_R14H
);

    localparam int CW = SIGFIG + 1;

    state_t                  r_state;
    logic signed [CW-1:0]    r_cur_x;
    logic signed [CW-1:0]    r_cur_y;
    logic signed [CW-1:0]    r_ll_x;
    logic signed [CW-1:0]    r_ur_x;
    logic signed [CW-1:0]    r_ur_y;
    logic signed [SIGFIG-1:0] r_tri [VERTS][AXIS];
    logic [SIGFIG-1:0]       r_color [COLORS];
    logic signed [SIGFIG-1:0] r_sample [2][SAMPS];
    logic [SAMPS-1:0]        r_vld;

    logic signed [CW-1:0]    w_step;
    logic signed [CW-1:0]    w_stride;
    logic signed [CW-1:0]    w_next_x;
    logic signed [CW-1:0]    w_next_y;
    logic signed [CW-1:0]    w_box_ll_x;
    logic signed [CW-1:0]    w_box_ll_y;
    logic signed [CW-1:0]    w_box_ur_x;
    logic signed [CW-1:0]    w_box_ur_y;
    logic                    w_adv_x;
    logic                    w_adv_y;
    logic signed [SIGFIG-1:0] w_lane_x [SAMPS];
    logic signed [SIGFIG-1:0] w_lane_y;
    logic [SAMPS-1:0]        w_lane_vld;

    assign w_step     = CW'(step_lookup(subSample_RnnnnU, RADIX));
    assign w_stride   = CW'(lane_offset(SAMPS, step_lookup(subSample_RnnnnU, RADIX)));
    assign w_next_x   = r_cur_x + w_stride;
    assign w_next_y   = r_cur_y + w_step;
    assign w_adv_x    = (w_next_x <= r_ur_x);
    assign w_adv_y    = (w_next_y <= r_ur_y);
    assign w_box_ll_x = {box_R13S[0][0][SIGFIG-1], box_R13S[0][0]};
    assign w_box_ll_y = {box_R13S[0][1][SIGFIG-1], box_R13S[0][1]};
    assign w_box_ur_x = {box_R13S[1][0][SIGFIG-1], box_R13S[1][0]};
    assign w_box_ur_y = {box_R13S[1][1][SIGFIG-1], box_R13S[1][1]};

    sample_lane_gen #(
        .SIGFIG (SIGFIG),
        .SAMPS  (SAMPS)
    ) u_lane_gen (
        .i_cur_x    (r_cur_x),
        .i_cur_y    (r_cur_y[SIGFIG-1:0]),
        .i_ur_x     (r_ur_x),
        .i_step     (w_step),
        .o_lane_x   (w_lane_x),
        .o_lane_y   (w_lane_y),
        .o_lane_vld (w_lane_vld)
    );

    // Walk cursor and box limits only matter inside a walk, so they carry no reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_WAIT) begin
            if (validTri_R13H) begin
                r_ll_x  <= w_box_ll_x;
                r_ur_x  <= w_box_ur_x;
                r_ur_y  <= w_box_ur_y;
                r_cur_x <= w_box_ll_x;
                r_cur_y <= w_box_ll_y;
            end
        end else if (w_adv_x) begin
            r_cur_x <= w_next_x;
        end else if (w_adv_y) begin
            r_cur_x <= r_ll_x;
            r_cur_y <= w_next_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_WAIT;
            r_vld   <= '0;
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++)
                    r_tri[v][a] <= '0;
            for (int c = 0; c < COLORS; c++)
                r_color[c] <= '0;
            for (int k = 0; k < SAMPS; k++) begin
                r_sample[0][k] <= '0;
                r_sample[1][k] <= '0;
            end
        end else begin
            case (r_state)
                ST_WAIT: begin
                    r_vld <= '0;
                    if (validTri_R13H) begin
                        r_tri   <= tri_R13S;
                        r_color <= color_R13U;
                        r_state <= ST_TEST;
                    end
                end
                ST_TEST: begin
                    r_vld <= w_lane_vld;
                    for (int k = 0; k < SAMPS; k++) begin
                        r_sample[0][k] <= w_lane_x[k];
                        r_sample[1][k] <= w_lane_y;
                    end
                    if (!w_adv_x && !w_adv_y)
                        r_state <= ST_WAIT;
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    assign halt_RnnnnL    = (r_state == ST_WAIT);
    assign tri_R14S       = r_tri;
    assign color_R14U     = r_color;
    assign sample_R14S    = r_sample;
    assign validSamp_R14H = r_vld;

    assert property (@(posedge clk) disable iff (!rst) $onehot(subSample_RnnnnU))
        else $error("sample_iter_multi: subSample_RnnnnU is not one-hot");

endmodule
